// File: rtl/dcache_controller.sv
// Direct-mapped, write-back/write-allocate data cache: 8 lines of 4 bytes, 8-bit CPU
// addresses, and a 6-bit block interface to main memory.
module dcache_controller (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        READ,
   input  logic        WRITE,
   input  logic [7:0]  ADDRESS,
   input  logic [7:0]  WRITEDATA,
   output logic [7:0]  READDATA,
   output logic        BUSYWAIT,
   output logic        MEM_READ,
   output logic        MEM_WRITE,
   output logic [5:0]  MEM_ADDRESS,
   output logic [31:0] MEM_WRITEDATA,
   input  logic [31:0] MEM_READDATA,
   input  logic        MEM_BUSYWAIT
);

   typedef enum logic [1:0] {IDLE, WRITE_BACK, FETCH, UPDATE} state_e;

   state_e      state_q;
   logic [31:0] data_q [8];
   logic [2:0]  tag_q  [8];
   logic [7:0]  valid_q;
   logic [7:0]  dirty_q;
   logic        mem_read_q;
   logic        mem_write_q;
   logic        started_q;
   logic [5:0]  mem_addr_q;
   logic [5:0]  fill_addr_q;
   logic [31:0] mem_wdata_q;

   logic [2:0]  index;
   logic [2:0]  tag_in;
   logic [1:0]  offset;
   logic [31:0] line;
   logic        hit;
   logic        request;
   logic        cpu_store;

   assign index     = ADDRESS[4:2];
   assign tag_in    = ADDRESS[7:5];
   assign offset    = ADDRESS[1:0];
   assign line      = data_q[index];
   assign hit       = valid_q[index] && (tag_q[index] == tag_in);
   assign request   = READ || WRITE;
   assign cpu_store = (state_q == IDLE) && hit && WRITE && !READ;

   assign READDATA      = line[{offset, 3'b000} +: 8];
   assign BUSYWAIT      = request && !((state_q == IDLE) && hit);
   assign MEM_READ      = mem_read_q;
   assign MEM_WRITE     = mem_write_q;
   assign MEM_ADDRESS   = mem_addr_q;
   assign MEM_WRITEDATA = mem_wdata_q;

   // Array contents need no reset: a cleared valid bit hides them.
   always_ff @(posedge CLK) begin
      if (state_q == UPDATE) begin
         data_q[fill_addr_q[2:0]] <= MEM_READDATA;
         tag_q[fill_addr_q[2:0]]  <= fill_addr_q[5:3];
      end else if (cpu_store) begin
         data_q[index][{offset, 3'b000} +: 8] <= WRITEDATA;
      end
   end

   // started_q ignores MEM_BUSYWAIT on the first edge of a transfer, so a memory
   // that raises busywait one cycle late is not mistaken for a completed one.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q     <= IDLE;
         valid_q     <= '0;
         dirty_q     <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         started_q   <= 1'b0;
         mem_addr_q  <= '0;
         fill_addr_q <= '0;
         mem_wdata_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (request && !hit) begin
                  fill_addr_q <= ADDRESS[7:2];
                  started_q   <= 1'b0;
                  if (valid_q[index] && dirty_q[index]) begin
                     state_q     <= WRITE_BACK;
                     mem_write_q <= 1'b1;
                     mem_addr_q  <= {tag_q[index], index};
                     mem_wdata_q <= line;
                  end else begin
                     state_q    <= FETCH;
                     mem_read_q <= 1'b1;
                     mem_addr_q <= ADDRESS[7:2];
                  end
               end else if (cpu_store) begin
                  dirty_q[index] <= 1'b1;
               end
            end
            WRITE_BACK: begin
               if (started_q && !MEM_BUSYWAIT) begin
                  state_q     <= FETCH;
                  mem_write_q <= 1'b0;
                  mem_read_q  <= 1'b1;
                  mem_addr_q  <= fill_addr_q;
                  started_q   <= 1'b0;
               end else begin
                  started_q <= 1'b1;
               end
            end
            FETCH: begin
               if (started_q && !MEM_BUSYWAIT) begin
                  state_q    <= UPDATE;
                  mem_read_q <= 1'b0;
                  started_q  <= 1'b0;
               end else begin
                  started_q <= 1'b1;
               end
            end
            UPDATE: begin
               state_q                  <= IDLE;
               valid_q[fill_addr_q[2:0]] <= 1'b1;
               dirty_q[fill_addr_q[2:0]] <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed and randomized checks of dcache_controller against a byte-level memory
// image and a tag/valid/dirty model, with a variable-latency block memory attached.
module tb_dcache_controller;

   logic        CLK, RESET, READ, WRITE;
   logic [7:0]  ADDRESS, WRITEDATA, READDATA;
   logic        BUSYWAIT, MEM_READ, MEM_WRITE;
   logic [5:0]  MEM_ADDRESS;
   logic [31:0] MEM_WRITEDATA, MEM_READDATA;
   logic        MEM_BUSYWAIT;

   dcache_controller dut (
      .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE),
      .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .READDATA(READDATA),
      .BUSYWAIT(BUSYWAIT), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
      .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITEDATA(MEM_WRITEDATA),
      .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Block memory: accepts a request, stays busy 1-4 cycles, then ignores the bus
   // for one edge while the cache reacts to the falling busywait.
   logic [31:0] mem [64];
   logic [31:0] mwdata;
   logic [5:0]  maddr;
   bit          mact, mcool, mwr, mseeded;
   int          mcnt;

   always @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         MEM_BUSYWAIT <= 1'b0;
         mact         <= 1'b0;
         mcool        <= 1'b0;
         if (!mseeded) begin
            for (int i = 0; i < 64; i++) mem[i] <= $urandom;
            mem[9]       <= 32'hDDCCBBAA;
            MEM_READDATA <= '0;
            mseeded      <= 1'b1;
         end
      end else if (mact) begin
         if (mcnt == 0) begin
            mact         <= 1'b0;
            MEM_BUSYWAIT <= 1'b0;
            mcool        <= 1'b1;
            if (mwr) mem[maddr] <= mwdata;
            else     MEM_READDATA <= mem[maddr];
         end else begin
            mcnt <= mcnt - 1;
         end
      end else if (mcool) begin
         mcool <= 1'b0;
      end else if (MEM_READ || MEM_WRITE) begin
         mact         <= 1'b1;
         MEM_BUSYWAIT <= 1'b1;
         mwr          <= MEM_WRITE;
         maddr        <= MEM_ADDRESS;
         mwdata       <= MEM_WRITEDATA;
         mcnt         <= $urandom_range(0, 3);
      end
   end

   // Reference: what each byte address should read as, plus which block each line holds.
   logic [7:0] gold [256];
   bit         rv [8];
   bit         rdirty [8];
   logic [2:0] rt [8];
   int         tests = 0;
   int         fails = 0;

   function automatic logic [31:0] blk(input logic [5:0] b);
      return {gold[{b, 2'd3}], gold[{b, 2'd2}], gold[{b, 2'd1}], gold[{b, 2'd0}]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic sync_model_from_memory();
      for (int b = 0; b < 64; b++)
         for (int k = 0; k < 4; k++) gold[b * 4 + k] = mem[b][k * 8 +: 8];
      for (int l = 0; l < 8; l++) begin
         rv[l] = 1'b0;
         rdirty[l] = 1'b0;
      end
   endtask

   task automatic access(input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] wd,
                         output logic [7:0] got, output logic [31:0] wbd);
      logic [2:0] idx;
      bit exp_hit;
      int n;
      idx = a[4:2];
      wbd = '0;
      @(negedge CLK);
      READ = rd; WRITE = wr; ADDRESS = a; WRITEDATA = wd;
      #1;
      exp_hit = rv[idx] && (rt[idx] == a[7:5]);
      chk("busywait_on_request", BUSYWAIT, !exp_hit);
      if (!exp_hit) begin
         if (rv[idx] && rdirty[idx]) begin
            n = 0;
            while (!MEM_WRITE && n < 100) begin @(negedge CLK); n++; end
            chk("wb_started", MEM_WRITE, 1);
            chk("wb_no_read", MEM_READ, 0);
            chk("wb_addr", MEM_ADDRESS, {rt[idx], idx});
            chk("wb_data", MEM_WRITEDATA, blk({rt[idx], idx}));
            wbd = MEM_WRITEDATA;
         end
         n = 0;
         while (!MEM_READ && n < 100) begin @(negedge CLK); n++; end
         chk("fetch_started", MEM_READ, 1);
         chk("fetch_no_write", MEM_WRITE, 0);
         chk("fetch_addr", MEM_ADDRESS, a[7:2]);
         n = 0;
         while (BUSYWAIT && n < 200) begin @(negedge CLK); n++; end
         chk("miss_resolved", BUSYWAIT, 0);
         rv[idx] = 1'b1;
         rt[idx] = a[7:5];
         rdirty[idx] = 1'b0;
      end
      got = READDATA;
      if (rd) chk("readdata", READDATA, gold[a]);
      else if (wr) begin
         gold[a] = wd;
         rdirty[idx] = 1'b1;
      end
      @(negedge CLK);
      READ = 1'b0; WRITE = 1'b0;
      #1;
      chk("idle_busywait", BUSYWAIT, 0);
      chk("idle_mem_req", {MEM_READ, MEM_WRITE}, 2'b00);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  got, old;
      logic [31:0] wbd;
      int          n;
      logic [7:0]  a;
      int          op;

      RESET = 1'b1; READ = 1'b0; WRITE = 1'b0; ADDRESS = '0; WRITEDATA = '0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("reset_mem_read", MEM_READ, 0);
      chk("reset_mem_write", MEM_WRITE, 0);
      chk("reset_busywait", BUSYWAIT, 0);
      RESET = 1'b0;
      sync_model_from_memory();

      access(1, 0, 8'h25, 8'h00, got, wbd);
      chk("cold_read_value", got, 8'hBB);
      access(1, 0, 8'h27, 8'h00, got, wbd);
      chk("hit_read_value", got, 8'hDD);

      access(0, 1, 8'h24, 8'h5A, got, wbd);
      access(1, 0, 8'h44, 8'h00, got, wbd);
      chk("evict_wb_value", wbd, 32'hDDCCBB5A);

      access(0, 1, 8'h80, 8'h77, got, wbd);
      access(1, 0, 8'h80, 8'h00, got, wbd);
      chk("write_alloc_value", got, 8'h77);

      access(1, 1, 8'h80, 8'h11, got, wbd);
      chk("both_high_read", got, 8'h77);
      access(1, 0, 8'h80, 8'h00, got, wbd);
      chk("both_high_no_store", got, 8'h77);

      // Store miss abandoned once the fetch is under way.
      old = gold[8'hE8];
      @(negedge CLK);
      WRITE = 1'b1; ADDRESS = 8'hE8; WRITEDATA = 8'h3C;
      n = 0;
      while (!MEM_READ && n < 100) begin @(negedge CLK); n++; end
      chk("abandon_fetch_started", MEM_READ, 1);
      WRITE = 1'b0;
      n = 0;
      while (MEM_READ && n < 100) begin @(negedge CLK); n++; end
      chk("abandon_fetch_done", MEM_READ, 0);
      @(negedge CLK);
      rv[2] = 1'b1; rt[2] = 3'd7; rdirty[2] = 1'b0;
      access(1, 0, 8'hE8, 8'h00, got, wbd);
      chk("abandon_no_store", got, old);

      // Reset during a fetch.
      @(negedge CLK);
      READ = 1'b1; ADDRESS = 8'h27;
      n = 0;
      while (!MEM_READ && n < 100) begin @(negedge CLK); n++; end
      chk("rst_fetch_started", MEM_READ, 1);
      RESET = 1'b1;
      #1;
      chk("rst_abort_mem_read", MEM_READ, 0);
      chk("rst_busy_with_req", BUSYWAIT, 1);
      READ = 1'b0;
      #1;
      chk("rst_busy_no_req", BUSYWAIT, 0);
      @(negedge CLK);
      RESET = 1'b0;
      sync_model_from_memory();
      access(1, 0, 8'h27, 8'h00, got, wbd);
      chk("post_reset_read", got, 8'hDD);

      for (int i = 0; i < 200; i++) begin
         a = 8'($urandom_range(0, 255));
         a[7] = 1'b0;
         op = $urandom_range(0, 2);
         access(op != 1, op != 0, a, 8'($urandom), got, wbd);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
